// File: rtl/clk_pkg.sv
// Shared types for consumers of the programmable clock divider output.
package clk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StDone
  } state_e;

  // Width that holds a count from 0 to width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Registered edge detector; rise_o/fall_o are single-cycle strobes in the clk_i domain.
module clk_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/dclk_shifter.sv
// Serial shift engine clocked by divider edges: drives sdo/sclk/cs_n and captures sdi
// (SPI mode 0 style).
module dclk_shifter
  import clk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          LSB_FIRST  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dclk_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  sclk_o,
  output logic                  sdo_o,
  input  logic                  sdi_i,
  output logic                  cs_no,
  output logic                  busy_o
);

  localparam int unsigned CntW = cnt_width(DATA_WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  sdo_q, sdo_d;
  logic                  sclk_q, cs_n_q, rx_valid_q;
  logic                  rise, fall;

  clk_edge_det u_edge_det (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sig_i  (dclk_i),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    cnt_d     = cnt_q;
    sdo_d     = sdo_q;
    case (state_q)
      StIdle: begin
        sdo_d = 1'b0;
        if (tx_valid_i) begin
          tx_sr_d = tx_data_i;
          rx_sr_d = '0;
          cnt_d   = '0;
          sdo_d   = LSB_FIRST ? tx_data_i[0] : tx_data_i[DATA_WIDTH-1];
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (fall) state_d = StShift;
      end
      StShift: begin
        if (rise) begin
          rx_sr_d = LSB_FIRST ? {sdi_i, rx_sr_q[DATA_WIDTH-1:1]}
                              : {rx_sr_q[DATA_WIDTH-2:0], sdi_i};
          cnt_d   = cnt_q + CntW'(1);
        end else if (fall) begin
          if (cnt_q == CntMax) begin
            rx_data_d = rx_sr_q;
            sdo_d     = 1'b0;
            state_d   = StDone;
          end else begin
            tx_sr_d = LSB_FIRST ? {1'b0, tx_sr_q[DATA_WIDTH-1:1]}
                                : {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
            sdo_d   = LSB_FIRST ? tx_sr_q[1] : tx_sr_q[DATA_WIDTH-2];
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      sdo_q      <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      sdo_q      <= sdo_d;
      // Registered from next state so sclk follows dclk one cycle late, never glitching.
      sclk_q     <= (state_d == StShift) & dclk_i;
      cs_n_q     <= ~((state_d == StSetup) || (state_d == StShift));
      rx_valid_q <= (state_d == StDone);
    end
  end

  assign tx_ready_o = (state_q == StIdle);
  assign busy_o     = (state_q != StIdle);
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign sclk_o     = sclk_q;
  assign sdo_o      = sdo_q;
  assign cs_no      = cs_n_q;

endmodule

// File: tb/tb_dclk_shifter.sv
// Bench for dclk_shifter: MSB-first loopback instance plus an LSB-first instance with sdi tied high.
module tb_dclk_shifter;
  import clk_pkg::*;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] tx;
    logic [W-1:0] rx;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic dclk = 1'b0;
  int unsigned div = 2;
  int unsigned div_cnt = 0;

  // MSB-first instance
  logic [W-1:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, sclk, sdo, sdi, cs_n, busy;
  // LSB-first instance
  logic [W-1:0] tx_data_b, rx_data_b;
  logic tx_valid_b, tx_ready_b, rx_valid_b, sclk_b, sdo_b, cs_n_b, busy_b;

  assign sdi = sdo;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t exp_b_q[$];

  always #5 clk_i = ~clk_i;

  // Divider model: dclk toggles every div cycles; div == 0 holds it low.
  always @(negedge clk_i) begin
    if (div == 0) begin
      dclk = 1'b0;
      div_cnt = 0;
    end else if (div_cnt + 1 >= div) begin
      dclk = ~dclk;
      div_cnt = 0;
    end else begin
      div_cnt++;
    end
  end

  dclk_shifter #(.DATA_WIDTH(W), .LSB_FIRST(1'b0)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dclk_i(dclk),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .sclk_o(sclk), .sdo_o(sdo),
    .sdi_i(sdi), .cs_no(cs_n), .busy_o(busy)
  );

  dclk_shifter #(.DATA_WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk_i(clk_i), .rst_ni(rst_ni), .dclk_i(dclk),
    .tx_data_i(tx_data_b), .tx_valid_i(tx_valid_b), .tx_ready_o(tx_ready_b),
    .rx_data_o(rx_data_b), .rx_valid_o(rx_valid_b), .sclk_o(sclk_b), .sdo_o(sdo_b),
    .sdi_i(1'b1), .cs_no(cs_n_b), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receiver model for the MSB-first instance.
  int pulses = 0, glitch = 0, gap = 100, frames = 0;
  logic [W-1:0] bits = '0;
  logic sclk_p = 1'b0, rxv_p = 1'b0, cs_p = 1'b1;
  exp_t e;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      pulses = 0; bits = '0; glitch = 0; gap = 100;
      sclk_p = 1'b0; rxv_p = 1'b0; cs_p = 1'b1;
    end else begin
      if (sclk && !sclk_p) begin
        pulses++;
        bits = {bits[W-2:0], sdo};
      end
      if (sclk && cs_n) glitch++;
      if (!cs_n && cs_p) check("idle_gap", 32'(gap >= 2), 1);
      gap = cs_n ? gap + 1 : 0;
      if (rx_valid) begin
        check("rxv_width", rxv_p, 0);
        check("cs_in_done", cs_n, 1);
        if (exp_q.size() == 0) begin
          check("rx_extra", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", rx_data, e.rx);
          check("sdo_bits", bits, e.tx);
          check("sclk_pulses", pulses, W);
          check("sclk_glitch", glitch, 0);
        end
        pulses = 0; bits = '0; glitch = 0;
        frames++;
      end
      sclk_p = sclk; rxv_p = rx_valid; cs_p = cs_n;
    end
  end

  // Receiver model for the LSB-first instance.
  int pulses_b = 0, frames_b = 0;
  logic [W-1:0] bits_b = '0;
  logic sclk_pb = 1'b0;
  exp_t eb;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      pulses_b = 0; bits_b = '0; sclk_pb = 1'b0;
    end else begin
      if (sclk_b && !sclk_pb) begin
        pulses_b++;
        bits_b = {sdo_b, bits_b[W-1:1]};
      end
      if (rx_valid_b) begin
        if (exp_b_q.size() == 0) begin
          check("rx_b_extra", exp_b_q.size(), 1);
        end else begin
          eb = exp_b_q.pop_front();
          check("rx_b_data", rx_data_b, eb.rx);
          check("sdo_b_bits", bits_b, eb.tx);
          check("sclk_b_pulses", pulses_b, W);
          check("cs_b_done", cs_n_b, 1);
        end
        pulses_b = 0; bits_b = '0;
        frames_b++;
      end
      sclk_pb = sclk_b;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 2000) begin @(negedge clk_i); n++; end
    if (!tx_ready) check("ready_timeout", tx_ready, 1);
  endtask

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] rx_exp, input bit push);
    wait_ready();
    tx_data = d;
    tx_valid = 1'b1;
    if (push) exp_q.push_back('{tx: d, rx: rx_exp});
    @(negedge clk_i);
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 3000) begin @(negedge clk_i); n++; end
    if (frames < target) check("frame_timeout", frames, target);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 2000) begin @(negedge clk_i); n++; end
    if (!busy) check("busy_timeout", busy, 1);
  endtask

  initial begin
    int n;
    int f0;
    tx_data = '0; tx_valid = 1'b0; tx_data_b = '0; tx_valid_b = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_sclk", sclk, 0);
    check("rst_sdo", sdo, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_busy", busy, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // MSB-first loopback, dclk period 4
    send(8'hA5, 8'hA5, 1'b1);
    wait_frames(1);
    repeat (10) @(negedge clk_i);
    check("rx_hold", rx_data, 8'hA5);

    // LSB-first, sdi high
    n = 0;
    while (!tx_ready_b && n < 100) begin @(negedge clk_i); n++; end
    tx_data_b = 8'h01; tx_valid_b = 1'b1;
    exp_b_q.push_back('{tx: 8'h01, rx: 8'hFF});
    @(negedge clk_i);
    tx_valid_b = 1'b0;
    n = 0;
    while (frames_b < 1 && n < 3000) begin @(negedge clk_i); n++; end
    if (frames_b < 1) check("frame_b_timeout", frames_b, 1);

    // dclk toggling every clk
    div = 1;
    repeat (4) @(negedge clk_i);
    send(8'h3C, 8'h3C, 1'b1);
    wait_frames(2);

    // tx_valid held across two frames; data change after acceptance only hits frame two
    div = 2;
    wait_ready();
    tx_data = 8'h11; tx_valid = 1'b1;
    exp_q.push_back('{tx: 8'h11, rx: 8'h11});
    @(negedge clk_i);
    wait_busy();
    tx_data = 8'h22;
    exp_q.push_back('{tx: 8'h22, rx: 8'h22});
    wait_frames(3);
    wait_busy();
    tx_valid = 1'b0;
    wait_frames(4);

    // Reset after three sclk rises
    send(8'h96, 8'h00, 1'b0);
    n = 0;
    while (pulses < 3 && n < 500) begin @(negedge clk_i); n++; end
    check("abort_pulses", pulses, 3);
    #2 rst_ni = 1'b0;
    #1;
    check("abort_cs_n", cs_n, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", tx_ready, 1);
    check("abort_sdo", sdo, 0);
    check("abort_rx_data", rx_data, 0);
    f0 = frames;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (40) @(negedge clk_i);
    check("abort_no_rxv", frames, f0);
    send(8'h5A, 8'h5A, 1'b1);
    wait_frames(f0 + 1);

    // dclk stuck low: frame parks in setup until the divider restarts
    div = 0;
    repeat (5) @(negedge clk_i);
    send(8'hFF, 8'hFF, 1'b1);
    repeat (50) @(negedge clk_i);
    check("stuck_state", 32'(u_dut.state_q), 32'(StSetup));
    check("stuck_busy", busy, 1);
    check("stuck_cs_n", cs_n, 0);
    check("stuck_sclk", sclk, 0);
    check("stuck_ready", tx_ready, 0);
    div = 4;
    wait_frames(f0 + 2);

    repeat (5) @(negedge clk_i);
    check("sb_empty", exp_q.size(), 0);
    check("sb_b_empty", exp_b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
